// File: rtl/axi_io_pmp_err_slv.sv
// AXI4 error responder for transactions denied by the IO-PMP: swallows write data,
// returns one error B per write and arlen+1 filler beats with an error RRESP per read.
module axi_io_pmp_err_slv #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ID_WIDTH    = 8,
  parameter int          BUSER_WIDTH = 1,
  parameter int          RUSER_WIDTH = 1,
  parameter logic [1:0]  RESP        = 2'b11,
  parameter logic [31:0] ERR_DATA    = 32'hBADCAB1E
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ID_WIDTH-1:0]    s_axi_awid,
  input  logic [7:0]             s_axi_awlen,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic                   s_axi_wlast,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [ID_WIDTH-1:0]    s_axi_bid,
  output logic [1:0]             s_axi_bresp,
  output logic [BUSER_WIDTH-1:0] s_axi_buser,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [ID_WIDTH-1:0]    s_axi_arid,
  input  logic [7:0]             s_axi_arlen,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [ID_WIDTH-1:0]    s_axi_rid,
  output logic [DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rlast,
  output logic [RUSER_WIDTH-1:0] s_axi_ruser,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [1:0]             dbg_w_state,
  output logic                   dbg_r_state,
  output logic [7:0]             dbg_w_beats,
  output logic [7:0]             dbg_w_len,
  output logic [7:0]             dbg_r_remaining
);

  // Handshake rule on every channel: a transfer happens on the rising clk edge where
  // valid and ready are both 1; a raised valid is held, with its payload stable, until then.

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  function automatic logic [DATA_WIDTH-1:0] fill_word();
    logic [DATA_WIDTH-1:0] f;
    for (int i = 0; i < DATA_WIDTH; i++) f[i] = ERR_DATA[i % 32];
    return f;
  endfunction

  localparam logic [DATA_WIDTH-1:0] FILL = fill_word();

  w_state_t              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id_next;
  logic [7:0]            w_beats, w_beats_next, w_len, w_len_next;
  r_state_t              r_state, r_next;
  logic [ID_WIDTH-1:0]   r_id_next;
  logic [7:0]            r_rem, r_rem_next;

  assign s_axi_bresp     = RESP;
  assign s_axi_rresp     = RESP;
  assign s_axi_buser     = '0;
  assign s_axi_ruser     = '0;
  assign s_axi_rdata     = FILL;
  assign dbg_w_state     = w_state;
  assign dbg_r_state     = r_state;
  assign dbg_w_beats     = w_beats;
  assign dbg_w_len       = w_len;
  assign dbg_r_remaining = r_rem;

  always_comb begin
    w_next       = w_state;
    w_id_next    = s_axi_bid;
    w_beats_next = w_beats;
    w_len_next   = w_len;
    case (w_state)
      W_IDLE: if (s_axi_awvalid && s_axi_awready) begin
        w_next       = W_DATA;
        w_id_next    = s_axi_awid;
        w_len_next   = s_axi_awlen;
        w_beats_next = 8'd0;
      end
      // wlast alone closes the burst; the beat count is kept only for observation.
      W_DATA: if (s_axi_wvalid && s_axi_wready) begin
        w_beats_next = w_beats + 8'd1;
        if (s_axi_wlast) w_next = W_RESP;
      end
      W_RESP: if (s_axi_bvalid && s_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      w_beats       <= 8'd0;
      w_len         <= 8'd0;
    end else begin
      w_state       <= w_next;
      s_axi_awready <= (w_next == W_IDLE);
      s_axi_wready  <= (w_next == W_DATA);
      s_axi_bvalid  <= (w_next == W_RESP);
      s_axi_bid     <= w_id_next;
      w_beats       <= w_beats_next;
      w_len         <= w_len_next;
    end
  end

  always_comb begin
    r_next     = r_state;
    r_id_next  = s_axi_rid;
    r_rem_next = r_rem;
    case (r_state)
      R_IDLE: if (s_axi_arvalid && s_axi_arready) begin
        r_next     = R_DATA;
        r_id_next  = s_axi_arid;
        r_rem_next = s_axi_arlen;
      end
      R_DATA: if (s_axi_rvalid && s_axi_rready) begin
        if (s_axi_rlast) r_next = R_IDLE;
        else             r_rem_next = r_rem - 8'd1;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      r_rem         <= 8'd0;
    end else begin
      r_state       <= r_next;
      s_axi_arready <= (r_next == R_IDLE);
      s_axi_rvalid  <= (r_next == R_DATA);
      s_axi_rlast   <= (r_next == R_DATA) && (r_rem_next == 8'd0);
      s_axi_rid     <= r_id_next;
      r_rem         <= r_rem_next;
    end
  end

endmodule

// File: tb/tb_axi_io_pmp_err_slv.sv
// Directed + randomized bench for axi_io_pmp_err_slv with a transaction-level
// scoreboard of owed B responses and R beats.
module tb_axi_io_pmp_err_slv;

  localparam logic [31:0] ERR_EXP  = 32'hBADCAB1E;
  localparam logic [1:0]  RESP_EXP = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s_axi_awid = '0, s_axi_awlen = '0, s_axi_arid = '0, s_axi_arlen = '0;
  logic        s_axi_awvalid = 0, s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_bready = 0;
  logic        s_axi_arvalid = 0, s_axi_rready = 0;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rlast, s_axi_rvalid;
  logic [7:0]  s_axi_bid, s_axi_rid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [0:0]  s_axi_buser, s_axi_ruser;
  logic [31:0] s_axi_rdata;
  logic [1:0]  dbg_w_state;
  logic        dbg_r_state;
  logic [7:0]  dbg_w_beats, dbg_w_len, dbg_r_remaining;

  int errors = 0;
  int checks = 0;
  logic [8:0] r_exp_q[$];   // {rid, rlast} per owed read beat
  logic [7:0] b_exp_q[$];   // bid per owed write response
  bit r_stalled = 0;
  bit b_stalled = 0;
  int waits;

  always #5 clk = ~clk;

  axi_io_pmp_err_slv dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_buser(s_axi_buser), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state), .dbg_w_beats(dbg_w_beats),
    .dbg_w_len(dbg_w_len), .dbg_r_remaining(dbg_r_remaining)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge; score the R and B channels against the owed queues.
  task automatic neg();
    logic [8:0] head;
    @(negedge clk);
    if (r_stalled) check("r_valid_held", s_axi_rvalid, 1);
    if (s_axi_rvalid) begin
      check("r_beat_owed", r_exp_q.size() > 0, 1);
      if (r_exp_q.size() > 0) begin
        head = r_exp_q[0];
        check("r_id", s_axi_rid, head[8:1]);
        check("r_last", s_axi_rlast, head[0]);
        check("r_data", s_axi_rdata, ERR_EXP);
        check("r_resp", s_axi_rresp, RESP_EXP);
        if (s_axi_rready) void'(r_exp_q.pop_front());
      end
    end
    r_stalled = s_axi_rvalid && !s_axi_rready;
    if (b_stalled) check("b_valid_held", s_axi_bvalid, 1);
    if (s_axi_bvalid) begin
      check("b_owed", b_exp_q.size() > 0, 1);
      if (b_exp_q.size() > 0) begin
        check("b_id", s_axi_bid, b_exp_q[0]);
        check("b_resp", s_axi_bresp, RESP_EXP);
        if (s_axi_bready) void'(b_exp_q.pop_front());
      end
    end
    b_stalled = s_axi_bvalid && !s_axi_bready;
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [7:0] id, input logic [7:0] len);
    bit hs = 0;
    s_axi_awid = id; s_axi_awlen = len; s_axi_awvalid = 1;
    for (int i = 0; i < 50 && !hs; i++) begin
      neg();
      hs = s_axi_awready;
      pos();
    end
    s_axi_awvalid = 0;
    check("aw_accept", hs, 1);
    b_exp_q.push_back(id);
  endtask

  task automatic do_ar(input logic [7:0] id, input logic [7:0] len);
    bit hs = 0;
    s_axi_arid = id; s_axi_arlen = len; s_axi_arvalid = 1;
    for (int b = 0; b <= int'(len); b++) r_exp_q.push_back({id, b == int'(len)});
    for (int i = 0; i < 50 && !hs; i++) begin
      neg();
      hs = s_axi_arready;
      pos();
    end
    s_axi_arvalid = 0;
    check("ar_accept", hs, 1);
  endtask

  task automatic send_w(input int n, input bit gaps, output int nwait);
    bit hs;
    nwait = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        s_axi_wvalid = 0; neg(); pos();
      end
      s_axi_wvalid = 1; s_axi_wlast = (k == n - 1);
      hs = 0;
      for (int i = 0; i < 50 && !hs; i++) begin
        neg();
        hs = s_axi_wready;
        if (!hs) nwait++;
        pos();
      end
      check("w_accept", hs, 1);
    end
    s_axi_wvalid = 0; s_axi_wlast = 0;
  endtask

  task automatic drain_r(input bit rnd);
    for (int i = 0; i < 3000 && r_exp_q.size() > 0; i++) begin
      s_axi_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      neg(); pos();
    end
    check("r_drained", r_exp_q.size(), 0);
    s_axi_rready = 0;
  endtask

  task automatic drain_b(input bit rnd);
    for (int i = 0; i < 300 && b_exp_q.size() > 0; i++) begin
      s_axi_bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      neg(); pos();
    end
    check("b_drained", b_exp_q.size(), 0);
    s_axi_bready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    pos(); pos();
    neg();
    check("rst_awready", s_axi_awready, 0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_bid", s_axi_bid, 0);
    check("rst_rid", s_axi_rid, 0);
    check("rst_rlast", s_axi_rlast, 0);
    check("rst_bresp", s_axi_bresp, RESP_EXP);
    check("rst_rresp", s_axi_rresp, RESP_EXP);
    check("rst_wbeats", dbg_w_beats, 0);
    pos();
    rst = 1;
    neg();
    check("awready_before_edge", s_axi_awready, 0);
    pos();
    neg();
    check("awready_after_release", s_axi_awready, 1);
    check("arready_after_release", s_axi_arready, 1);
    pos();

    // Write id 0x5A, 4 beats, bready high
    s_axi_bready = 1;
    do_aw(8'h5A, 8'd3);
    send_w(4, 0, waits);
    check("w_first_accept_latency", waits, 0);
    neg();
    check("b_latency", s_axi_bvalid, 1);
    check("b_id_5a", s_axi_bid, 8'h5A);
    pos();
    neg();
    check("awready_after_b", s_axi_awready, 1);
    check("b_single", s_axi_bvalid, 0);
    check("w_beat_count", dbg_w_beats, 4);
    check("w_len_latched", dbg_w_len, 3);
    pos();
    s_axi_bready = 0;

    // Single-beat read
    s_axi_rready = 1;
    do_ar(8'h11, 8'd0);
    neg();
    check("r_latency", s_axi_rvalid, 1);
    check("r_single_last", s_axi_rlast, 1);
    pos();
    neg();
    check("r_single_done", s_axi_rvalid, 0);
    check("arready_after_r", s_axi_arready, 1);
    pos();

    // 256-beat read with random rready
    s_axi_rready = 0;
    do_ar(8'($urandom), 8'd255);
    drain_r(1);
    neg();
    check("r_256_no_extra", s_axi_rvalid, 0);
    pos();

    // Simultaneous AW and AR; B stalled while R finishes
    s_axi_rready = 1; s_axi_bready = 0;
    s_axi_awid = 8'h33; s_axi_awlen = 8'd0; s_axi_awvalid = 1;
    s_axi_arid = 8'h44; s_axi_arlen = 8'd5; s_axi_arvalid = 1;
    for (int b = 0; b <= 5; b++) r_exp_q.push_back({8'h44, b == 5});
    b_exp_q.push_back(8'h33);
    neg();
    check("sim_awready", s_axi_awready, 1);
    check("sim_arready", s_axi_arready, 1);
    pos();
    s_axi_awvalid = 0; s_axi_arvalid = 0;
    neg();
    check("sim_aw_taken", s_axi_awready, 0);
    check("sim_ar_taken", s_axi_arready, 0);
    check("sim_rvalid", s_axi_rvalid, 1);
    check("sim_wready", s_axi_wready, 1);
    pos();
    send_w(1, 0, waits);
    for (int i = 0; i < 10; i++) begin
      neg();
      check("b_held_stalled", s_axi_bvalid, 1);
      pos();
    end
    check("r_done_independent", r_exp_q.size(), 0);
    s_axi_bready = 1;
    neg(); pos();
    neg();
    check("b_once", s_axi_bvalid, 0);
    check("b_queue_empty", b_exp_q.size(), 0);
    pos();
    s_axi_bready = 0;

    // W presented before AW, then short burst vs awlen=7
    s_axi_wvalid = 1; s_axi_wlast = 0;
    for (int i = 0; i < 3; i++) begin
      neg();
      check("w_held_off", s_axi_wready, 0);
      pos();
    end
    s_axi_wvalid = 0;
    do_aw(8'hC3, 8'd7);
    send_w(2, 0, waits);
    drain_b(0);

    // Reset during beat 3 of an 8-beat read
    s_axi_rready = 1;
    do_ar(8'h66, 8'd7);
    for (int i = 0; i < 3; i++) begin neg(); pos(); end
    rst = 0;
    #1;
    check("r_abort_on_rst", s_axi_rvalid, 0);
    check("arready_in_rst", s_axi_arready, 0);
    r_exp_q.delete(); b_exp_q.delete();
    r_stalled = 0; b_stalled = 0;
    pos(); pos();
    rst = 1;
    neg();
    check("arready_pre_edge", s_axi_arready, 0);
    pos();
    neg();
    check("arready_first_edge", s_axi_arready, 1);
    pos();
    for (int i = 0; i < 5; i++) begin
      neg();
      check("no_stale_r", s_axi_rvalid, 0);
      pos();
    end
    s_axi_rready = 0;

    // Randomized traffic
    for (int k = 0; k < 8; k++) begin
      do_ar(8'($urandom), 8'($urandom_range(0, 7)));
      drain_r(1);
      do_aw(8'($urandom), 8'($urandom_range(0, 7)));
      send_w($urandom_range(1, 4), 1, waits);
      drain_b(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_io_pmp_err_slv.md
Name: axi_io_pmp_err_slv

Overview:
- AXI4 error responder on the denied path of the IO-PMP.
- Transactions that the PMP check rejects are steered here instead of downstream. The block accepts them fully protocol-compliantly and answers them with an error response, so the upstream master never hangs.
- Write data is swallowed. Read bursts return the full arlen+1 beats of filler data.

Parameters:
- DATA_WIDTH, 32, width of rdata/wdata in bits.
- ID_WIDTH, 8, width of AXI id signals.
- BUSER_WIDTH, 1, width of buser (driven 0).
- RUSER_WIDTH, 1, width of ruser (driven 0).
- RESP, 2'b11, response code on bresp/rresp (DECERR; 2'b10 selects SLVERR).
- ERR_DATA, 32'hBADCAB1E, filler word, replicated/truncated to DATA_WIDTH on rdata.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  reset, asynchronous assert, active-low.
- s_axi_awid  in  ID_WIDTH  write id.
- s_axi_awlen  in  8  write burst length-1 (informational, latched).
- s_axi_awvalid  in  1  AW valid.
- s_axi_awready  out  1  AW ready.
- s_axi_wlast  in  1  last write beat.
- s_axi_wvalid  in  1  W valid.
- s_axi_wready  out  1  W ready.
- s_axi_bid  out  ID_WIDTH  response id.
- s_axi_bresp  out  2  write response.
- s_axi_buser  out  BUSER_WIDTH  constant 0.
- s_axi_bvalid  out  1  B valid.
- s_axi_bready  in  1  B ready.
- s_axi_arid  in  ID_WIDTH  read id.
- s_axi_arlen  in  8  read burst length-1.
- s_axi_arvalid  in  1  AR valid.
- s_axi_arready  out  1  AR ready.
- s_axi_rid  out  ID_WIDTH  read id.
- s_axi_rdata  out  DATA_WIDTH  filler data.
- s_axi_rresp  out  2  read response.
- s_axi_rlast  out  1  last read beat.
- s_axi_ruser  out  RUSER_WIDTH  constant 0.
- s_axi_rvalid  out  1  R valid.
- s_axi_rready  in  1  R ready.

Behaviour:

Outputs and reset
- All outputs are registered.
- While rst=0: every valid and ready is 0; bid, rid, rlast and counters are 0; bresp and rresp hold RESP.
- awready and arready rise on the first clk edge after rst releases.
- rst assertion mid-burst aborts immediately to IDLE. No B or R is owed after reset.

Write FSM (W_IDLE, W_DATA, W_RESP)
- W_IDLE: awready=1, wready=0. An AW handshake latches awid and goes to W_DATA. awready drops the next cycle.
- W_DATA: wready=1. Each W handshake increments an 8-bit beat counter. A handshake with wlast=1 ends the data phase and goes to W_RESP.
- wlast is authoritative. A beat count mismatching awlen is ignored (no hang, no extra B).
- W_RESP: bvalid=1, bid=latched id, bresp=RESP.
  - bvalid holds until bready.
  - On handshake, return to W_IDLE; awready=1 the next cycle.
- W beats presented before AW are held off (wready=0 in W_IDLE).
- One outstanding write.
- Minimum latency: AW at cycle T, first W accept T+1, bvalid the cycle after the wlast handshake.

Read FSM (R_IDLE, R_DATA)
- R_IDLE: arready=1. An AR handshake latches arid and loads remaining=arlen, then goes to R_DATA (rvalid=1 at T+1).
- R_DATA: rvalid=1, rdata=ERR_DATA, rresp=RESP, rid=latched id, rlast=(remaining==0).
  - Each R handshake decrements remaining.
  - The handshake with rlast=1 returns to R_IDLE.
- rvalid/rdata are stable while rready=0.
- arlen=255 yields exactly 256 beats; the counter does not wrap.
- Back-to-back rready=1 gives one beat per cycle.
- One outstanding read.

Channel independence
- Read and write FSMs are fully independent.
- Simultaneous AW and AR handshakes in the same cycle are both accepted.

Test Plan:
- AW id=0x5A, len=3, 4 W beats (wlast on 4th), bready=1 -> one B, bid=0x5A, bresp=2'b11, exactly 1 cycle after the wlast handshake; awready=1 the next cycle.
- AR id=0x11, len=0 -> single R beat at T+1: rdata=0xBADCAB1E, rresp=2'b11, rlast=1, rid=0x11.
- AR len=255, rready toggled randomly -> exactly 256 beats; rlast only on the 256th; data stable while stalled.
- AW and AR in the same cycle, bready=0 for 10 cycles -> R burst completes independently; bvalid held 10 cycles, then a single B.
- W beats before AW -> wready=0 until AW accepted; wlast after 2 beats with awlen=7 -> B issued anyway, no hang.
- rst=0 asserted mid-read burst (beat 3 of 8) -> rvalid=0 immediately; after release, arready=1 on the first edge and no stale beats appear.
